// File: rtl/isp_pkg.sv
// Shared codes for the ISP raw pixel-stream blocks: patterns, CFA channels,
// generator FSM states and the LFSR used for noise and dithering.
package isp_pkg;

    localparam logic [1:0] PAT_FLAT  = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_BARS  = 2'd2;
    localparam logic [1:0] PAT_NOISE = 2'd3;

    localparam logic [1:0] CH_B  = 2'd0;
    localparam logic [1:0] CH_GB = 2'd1;
    localparam logic [1:0] CH_GR = 2'd2;
    localparam logic [1:0] CH_R  = 2'd3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_VSYNC  = 3'd1;
    localparam logic [2:0] ST_VBACK  = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_VFRONT = 3'd4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Galois form, shifting right, feedback from the bit shifted out
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/isp_lfsr16.sv
// 16-bit Galois LFSR with seed load and step enable.
// A same-cycle load and advance yields the seed already stepped once.
module isp_lfsr16
    import isp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] state
);

    logic [15:0] base;

    assign base = load ? LFSR_SEED : state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LFSR_SEED;
        end else begin
            state <= advance ? lfsr_step(base) : base;
        end
    end

endmodule

// File: rtl/isp_raw_tpg.sv
// Bayer raw test-pattern generator driving the href/vsync/raw pixel stream.
// Counters hold the cycle currently on the outputs; outputs register the next one.
module isp_raw_tpg
    import isp_pkg::*;
#(
    parameter int BITS     = 8,
    parameter int WIDTH    = 1280,
    parameter int HEIGHT   = 960,
    parameter int BAYER    = 0,
    parameter int H_BLANK  = 160,
    parameter int VS_LINES = 2,
    parameter int VB_LINES = 20,
    parameter int VF_LINES = 4
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            enable,
    input  logic [1:0]      pattern,
    output logic            out_href,
    output logic            out_vsync,
    output logic [BITS-1:0] out_raw,
    output logic [15:0]     frame_cnt
);

    localparam int LINE = WIDTH + H_BLANK;
    localparam int HW   = $clog2(LINE);
    localparam int SEG  = WIDTH / 8;
    localparam int SW   = (SEG > 1) ? $clog2(SEG) : 1;
    localparam logic [1:0] BAY = BAYER[1:0];

    logic [2:0]      st, ns;
    logic [HW-1:0]   h_cnt, nh;
    logic [15:0]     line_cnt, nl;
    logic [SW-1:0]   seg, nseg;
    logic [2:0]      bar, nbar;
    logic [1:0]      pat, npat;
    logic            start, fdone, nhref;
    logic [15:0]     lfsr_q, noise_val;
    logic [1:0]      ch;
    logic [2:0]      v;
    logic            on;
    logic [BITS-1:0] pix;

    function automatic int lines_of(input logic [2:0] s);
        case (s)
            ST_VSYNC:  return VS_LINES;
            ST_VBACK:  return VB_LINES;
            ST_ACTIVE: return HEIGHT;
            ST_VFRONT: return VF_LINES;
            default:   return 0;
        endcase
    endfunction

    // ST_IDLE as a successor marks the end of a frame
    function automatic logic [2:0] succ(input logic [2:0] s);
        case (s)
            ST_VSYNC:  return ST_VBACK;
            ST_VBACK:  return ST_ACTIVE;
            ST_ACTIVE: return ST_VFRONT;
            default:   return ST_IDLE;
        endcase
    endfunction

    function automatic logic [2:0] skip_empty(input logic [2:0] s);
        logic [2:0] r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (r != ST_IDLE && lines_of(r) == 0) r = succ(r);
        end
        return r;
    endfunction

    always_comb begin
        ns    = st;
        nh    = h_cnt;
        nl    = line_cnt;
        start = 1'b0;
        fdone = 1'b0;
        if (st == ST_IDLE) begin
            if (enable) begin
                ns    = skip_empty(ST_VSYNC);
                start = 1'b1;
                nh    = '0;
                nl    = '0;
            end
        end else if (h_cnt == HW'(LINE - 1)) begin
            nh = '0;
            if (int'(line_cnt) == lines_of(st) - 1) begin
                nl = '0;
                ns = skip_empty(succ(st));
                if (ns == ST_IDLE) begin
                    fdone = 1'b1;
                    if (enable) begin
                        ns    = skip_empty(ST_VSYNC);
                        start = 1'b1;
                    end
                end
            end else begin
                nl = line_cnt + 16'd1;
            end
        end else begin
            nh = h_cnt + HW'(1);
        end
    end

    // Bar tracking without a divider: segment counter rolls into bar index
    always_comb begin
        nseg = seg;
        nbar = bar;
        if (nh == '0) begin
            nseg = '0;
            nbar = '0;
        end else if (seg == SW'(SEG - 1)) begin
            nseg = '0;
            nbar = bar + 3'd1;
        end else begin
            nseg = seg + SW'(1);
        end
    end

    assign npat      = start ? pattern : pat;
    assign nhref     = (ns == ST_ACTIVE) && (nh < HW'(WIDTH));
    assign noise_val = start ? LFSR_SEED : lfsr_q;
    assign ch        = {nl[0] ^ BAY[1], nh[0] ^ BAY[0]};
    assign v         = ~nbar;

    always_comb begin
        on = 1'b0;
        unique case (ch)
            CH_R:         on = v[2];
            CH_GB, CH_GR: on = v[1];
            CH_B:         on = v[0];
        endcase
    end

    always_comb begin
        pix = '0;
        unique case (npat)
            PAT_FLAT:  pix[BITS-1] = 1'b1;
            PAT_RAMP:  pix = BITS'(nh);
            PAT_BARS:  pix = {BITS{on}};
            PAT_NOISE: pix = BITS'(noise_val >> (16 - BITS));
        endcase
    end

    isp_lfsr16 u_lfsr (
        .clk     (pclk),
        .rst     (rst),
        .load    (start),
        .advance (nhref),
        .state   (lfsr_q)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            st        <= ST_IDLE;
            h_cnt     <= '0;
            line_cnt  <= '0;
            seg       <= '0;
            bar       <= '0;
            pat       <= PAT_FLAT;
            out_href  <= 1'b0;
            out_vsync <= 1'b0;
            out_raw   <= '0;
            frame_cnt <= '0;
        end else begin
            st        <= ns;
            h_cnt     <= nh;
            line_cnt  <= nl;
            seg       <= nseg;
            bar       <= nbar;
            pat       <= npat;
            out_href  <= nhref;
            out_vsync <= (ns == ST_VSYNC);
            out_raw   <= nhref ? pix : '0;
            frame_cnt <= frame_cnt + {15'd0, fdone};
        end
    end

endmodule

// File: tb/tb_isp_raw_tpg.sv
// Bench for isp_raw_tpg: frame-position reference model checked every cycle
// on two instances (BGGR and RGGB), plus directed timing and literal checks.
module tb_isp_raw_tpg;

    localparam int W     = 16;
    localparam int H     = 4;
    localparam int LINE  = 20;
    localparam int FRAME = 140;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic        href0, vs0, href3, vs3;
    logic [7:0]  raw0, raw3;
    logic [15:0] fc0, fc3;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] noise_tab [64];

    bit          m_run = 1'b0;
    int          m_pos = 0;
    int          m_pat = 0;
    logic [15:0] m_fc  = 16'd0;

    always #5 clk = ~clk;

    isp_raw_tpg #(
        .BITS(8), .WIDTH(W), .HEIGHT(H), .BAYER(0), .H_BLANK(4),
        .VS_LINES(1), .VB_LINES(1), .VF_LINES(1)
    ) dut0 (
        .pclk(clk), .rst(rst), .enable(enable), .pattern(pattern),
        .out_href(href0), .out_vsync(vs0), .out_raw(raw0), .frame_cnt(fc0)
    );

    isp_raw_tpg #(
        .BITS(8), .WIDTH(W), .HEIGHT(H), .BAYER(3), .H_BLANK(4),
        .VS_LINES(1), .VB_LINES(1), .VF_LINES(1)
    ) dut3 (
        .pclk(clk), .rst(rst), .enable(enable), .pattern(pattern),
        .out_href(href3), .out_vsync(vs3), .out_raw(raw3), .frame_cnt(fc3)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix(input int pat, input int bay,
                                       input int x, input int y);
        int bar, v, c;
        bit on;
        case (pat)
            0: return 8'h80;
            1: return 8'(x % 256);
            2: begin
                bar = x / (W / 8);
                v = 7 - bar;
                c = 2 * ((y % 2) ^ (bay / 2)) + ((x % 2) ^ (bay % 2));
                if (c == 3) on = v[2];
                else if (c == 0) on = v[0];
                else on = v[1];
                return on ? 8'hFF : 8'h00;
            end
            default: return noise_tab[y * W + x];
        endcase
    endfunction

    // Frame layout: line 0 vsync, line 1 back porch, lines 2..5 active, line 6 front
    function automatic logic [25:0] model_out(input int bay);
        int line, h;
        logic hr, vs;
        logic [7:0] r;
        hr = 1'b0;
        vs = 1'b0;
        r = 8'd0;
        if (m_run) begin
            line = m_pos / LINE;
            h = m_pos % LINE;
            vs = (line == 0);
            if (line >= 2 && line < 2 + H && h < W) begin
                hr = 1'b1;
                r = pix(m_pat, bay, h, line - 2);
            end
        end
        return {hr, vs, r, m_fc};
    endfunction

    always begin
        @(posedge clk);
        if (rst) begin
            m_run = 1'b0;
            m_pos = 0;
            m_fc = 16'd0;
        end else if (!m_run) begin
            if (enable) begin
                m_run = 1'b1;
                m_pos = 0;
                m_pat = int'(pattern);
            end
        end else begin
            m_pos++;
            if (m_pos == FRAME) begin
                m_fc++;
                if (enable) begin
                    m_pos = 0;
                    m_pat = int'(pattern);
                end else begin
                    m_run = 1'b0;
                end
            end
        end
        #1;
        chk("stream_bggr", {6'd0, href0, vs0, raw0, fc0}, {6'd0, model_out(0)});
        chk("stream_rggb", {6'd0, href3, vs3, raw3, fc3}, {6'd0, model_out(3)});
    end

    task automatic wait_frame();
        logic [15:0] f;
        int n;
        f = fc0;
        n = 0;
        while (fc0 == f && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("frame_wait", {31'd0, fc0 != f}, 32'd1);
    endtask

    task automatic wait_href();
        int n;
        n = 0;
        while (href0 !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("href_wait", {31'd0, href0}, 32'd1);
    endtask

    initial begin
        logic [15:0] s;
        int vs_n, hr_n;
        logic [15:0] f0;
        int pats [4];

        s = 16'hACE1;
        for (int i = 0; i < 64; i++) begin
            noise_tab[i] = s[15:8];
            s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
        end

        chk("pin_noise0", {24'd0, noise_tab[0]}, 32'hAC);
        chk("pin_noise1", {24'd0, noise_tab[1]}, 32'hE2);
        chk("pin_noise2", {24'd0, noise_tab[2]}, 32'h71);
        chk("pin_bar_x0", {24'd0, pix(2, 0, 0, 0)}, 32'hFF);
        chk("pin_bar_x10", {24'd0, pix(2, 0, 10, 0)}, 32'h00);
        chk("pin_bar_x11", {24'd0, pix(2, 0, 11, 0)}, 32'hFF);
        chk("pin_bar_x14", {24'd0, pix(2, 0, 14, 0)}, 32'h00);
        chk("pin_rggb_b", {24'd0, pix(2, 3, 11, 1)}, 32'h00);
        chk("pin_ramp", {24'd0, pix(1, 0, 5, 2)}, 32'h05);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", {href0, vs0, raw0, fc0}, 26'd0);

        enable = 1'b1;
        pattern = 2'd0;
        vs_n = 0;
        hr_n = 0;
        repeat (FRAME) begin
            @(negedge clk);
            vs_n += int'(vs0);
            hr_n += int'(href0);
        end
        @(negedge clk);
        chk("vsync_cycles", vs_n, 20);
        chk("href_cycles", hr_n, 64);
        chk("frame_cnt_1", {16'd0, fc0}, 32'd1);

        pats = '{1, 2, 3, 3};
        foreach (pats[k]) begin
            pattern = 2'(pats[k]);
            wait_frame();
            if (pats[k] == 3) begin
                wait_href();
                chk("noise_px0", {24'd0, raw0}, 32'hAC);
                @(negedge clk);
                chk("noise_px1", {24'd0, raw0}, 32'hE2);
                @(negedge clk);
                chk("noise_px2", {24'd0, raw0}, 32'h71);
            end
            repeat ($urandom_range(5, 100)) @(negedge clk);
            pattern = 2'($urandom);
        end

        enable = 1'b0;
        wait_frame();
        repeat (5) @(negedge clk);
        chk("idle_after_stop", {href0, vs0, raw0}, 10'd0);

        f0 = fc0;
        enable = 1'b1;
        pattern = 2'd2;
        repeat (30) @(negedge clk);
        enable = 1'b0;
        pattern = 2'd1;
        repeat (120) @(negedge clk);
        chk("drop_frame_cnt", {16'd0, fc0}, {16'd0, f0 + 16'd1});
        chk("drop_idle", {href0, vs0, raw0}, 10'd0);
        repeat (20) @(negedge clk);
        chk("drop_stays_idle", {16'd0, fc0}, {16'd0, f0 + 16'd1});

        enable = 1'b1;
        wait_href();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_outputs", {href0, vs0, raw0, fc0}, 26'd0);
        rst = 1'b0;
        wait_frame();
        chk("restart_cnt", {16'd0, fc0}, 32'd1);

        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            pattern = 2'($urandom);
            rst = ($urandom_range(0, 996) == 0);
        end
        rst = 1'b0;
        enable = 1'b0;
        repeat (300) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
